// File: rtl/and_response_checker.sv
// Response-side checker for a bitwise-AND datapath: aligns expected a&b to the DUT latency,
// counts matching/mismatching results and captures the first mismatch of each run.
module and_response_checker #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned LATENCY = 0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vectors,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [WIDTH-1:0] first_fail_got,
   output logic [WIDTH-1:0] first_fail_exp
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] pass_count_q, pass_count_d;
   logic [CNT_W-1:0] fail_count_q, fail_count_d;
   logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
   logic [WIDTH-1:0] ff_got_q, ff_got_d;
   logic [WIDTH-1:0] ff_exp_q, ff_exp_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   logic             push;
   logic [WIDTH-1:0] push_exp;
   logic             cmp_valid;
   logic [WIDTH-1:0] cmp_exp;
   logic [CNT_W-1:0] cmp_idx;
   logic             pending;

   // Vectors beyond num_vectors are not issued, so issued never passes the latched count.
   assign push     = (state_q == StRun) && in_valid && (issued_q != num_q);
   assign push_exp = a & b;

   generate
      if (LATENCY == 0) begin : g_comb
         assign cmp_valid = push;
         assign cmp_exp   = push_exp;
         assign cmp_idx   = issued_q;
         assign pending   = 1'b0;
      end else begin : g_line
         localparam int unsigned Depth = LATENCY;

         logic [Depth-1:0] vld_q;
         logic [WIDTH-1:0] exp_q [Depth];
         logic [CNT_W-1:0] idx_q [Depth];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q <= '0;
               for (int i = 0; i < int'(Depth); i++) begin
                  exp_q[i] <= '0;
                  idx_q[i] <= '0;
               end
            end else begin
               vld_q[0] <= push;
               exp_q[0] <= push_exp;
               idx_q[0] <= issued_q;
               for (int i = 1; i < int'(Depth); i++) begin
                  vld_q[i] <= vld_q[i-1];
                  exp_q[i] <= exp_q[i-1];
                  idx_q[i] <= idx_q[i-1];
               end
            end
         end

         assign cmp_valid = vld_q[Depth-1];
         assign cmp_exp   = exp_q[Depth-1];
         assign cmp_idx   = idx_q[Depth-1];

         // The last stage is compared this cycle, so only earlier stages keep DRAIN alive.
         if (Depth > 1) begin : g_pend
            assign pending = |vld_q[Depth-2:0];
         end else begin : g_no_pend
            assign pending = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      issued_d     = issued_q;
      pass_count_d = pass_count_q;
      fail_count_d = fail_count_q;
      ff_idx_d     = ff_idx_q;
      ff_got_d     = ff_got_q;
      ff_exp_d     = ff_exp_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d      = StRun;
               num_d        = num_vectors;
               issued_d     = '0;
               pass_count_d = '0;
               fail_count_d = '0;
               ff_idx_d     = '0;
               ff_got_d     = '0;
               ff_exp_d     = '0;
            end
         end
         StRun: begin
            if (push) begin
               issued_d = issued_q + CntOne;
            end
            if (issued_d == num_q) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (!pending) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase

      if (cmp_valid) begin
         if (dut_out == cmp_exp) begin
            if (pass_count_q != CntMax) begin
               pass_count_d = pass_count_q + CntOne;
            end
         end else begin
            if (fail_count_q == '0) begin
               ff_idx_d = cmp_idx;
               ff_got_d = dut_out;
               ff_exp_d = cmp_exp;
            end
            if (fail_count_q != CntMax) begin
               fail_count_d = fail_count_q + CntOne;
            end
         end
      end

      done_d = (state_d == StDone);
      pass_d = done_d && (fail_count_d == '0) && (pass_count_d == num_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         num_q        <= '0;
         issued_q     <= '0;
         pass_count_q <= '0;
         fail_count_q <= '0;
         ff_idx_q     <= '0;
         ff_got_q     <= '0;
         ff_exp_q     <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         issued_q     <= issued_d;
         pass_count_q <= pass_count_d;
         fail_count_q <= fail_count_d;
         ff_idx_q     <= ff_idx_d;
         ff_got_q     <= ff_got_d;
         ff_exp_q     <= ff_exp_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   assign busy           = (state_q == StRun) || (state_q == StDrain);
   assign done           = done_q;
   assign pass           = pass_q;
   assign pass_count     = pass_count_q;
   assign fail_count     = fail_count_q;
   assign first_fail_idx = ff_idx_q;
   assign first_fail_got = ff_got_q;
   assign first_fail_exp = ff_exp_q;

endmodule

// File: tb/tb_and_response_checker.sv
// Bench for and_response_checker: three instances (latency 0, latency 2, 2-bit counters)
// driven with directed and random runs, checked against a run-level statistics model.
module tb_and_response_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_l0, start_l2, start_c2;
   logic [15:0] num16;
   logic [1:0]  num2;
   logic        in_valid;
   logic [3:0]  a, b, cur_got, got_d1, got_d2;

   // Latency-2 DUT stand-in: whatever result is presented now appears two cycles later.
   always_ff @(posedge clk) begin
      got_d1 <= cur_got;
      got_d2 <= got_d1;
   end

   logic        l0_busy, l0_done, l0_pass, l2_busy, l2_done, l2_pass, c2_busy, c2_done, c2_pass;
   logic [15:0] l0_pc, l0_fc, l0_idx, l2_pc, l2_fc, l2_idx;
   logic [1:0]  c2_pc, c2_fc, c2_idx;
   logic [3:0]  l0_got, l0_exp, l2_got, l2_exp, c2_got, c2_exp;

   and_response_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(16)) u_l0 (
      .clk(clk), .rst_n(rst_n), .start(start_l0), .num_vectors(num16), .in_valid(in_valid),
      .a(a), .b(b), .dut_out(cur_got), .busy(l0_busy), .done(l0_done), .pass(l0_pass),
      .pass_count(l0_pc), .fail_count(l0_fc), .first_fail_idx(l0_idx),
      .first_fail_got(l0_got), .first_fail_exp(l0_exp)
   );

   and_response_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(16)) u_l2 (
      .clk(clk), .rst_n(rst_n), .start(start_l2), .num_vectors(num16), .in_valid(in_valid),
      .a(a), .b(b), .dut_out(got_d2), .busy(l2_busy), .done(l2_done), .pass(l2_pass),
      .pass_count(l2_pc), .fail_count(l2_fc), .first_fail_idx(l2_idx),
      .first_fail_got(l2_got), .first_fail_exp(l2_exp)
   );

   and_response_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .start(start_c2), .num_vectors(num2), .in_valid(in_valid),
      .a(a), .b(b), .dut_out(cur_got), .busy(c2_busy), .done(c2_done), .pass(c2_pass),
      .pass_count(c2_pc), .fail_count(c2_fc), .first_fail_idx(c2_idx),
      .first_fail_got(c2_got), .first_fail_exp(c2_exp)
   );

   int          sel;
   logic        o_busy, o_done, o_pass;
   logic [15:0] o_pc, o_fc, o_idx;
   logic [3:0]  o_got, o_exp;

   always_comb begin
      o_busy = l0_busy; o_done = l0_done; o_pass = l0_pass;
      o_pc = l0_pc; o_fc = l0_fc; o_idx = l0_idx; o_got = l0_got; o_exp = l0_exp;
      if (sel == 1) begin
         o_busy = l2_busy; o_done = l2_done; o_pass = l2_pass;
         o_pc = l2_pc; o_fc = l2_fc; o_idx = l2_idx; o_got = l2_got; o_exp = l2_exp;
      end else if (sel == 2) begin
         o_busy = c2_busy; o_done = c2_done; o_pass = c2_pass;
         o_pc = {14'd0, c2_pc}; o_fc = {14'd0, c2_fc}; o_idx = {14'd0, c2_idx};
         o_got = c2_got; o_exp = c2_exp;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] va[$], vb[$], vg[$];
   int         vbub[$];

   int m_pass, m_fail, m_idx, m_got, m_exp, m_pflag;
   int done_lat;
   logic s_busy, s_done;
   logic [15:0] s_pc, s_fc, s_idx;

   task automatic clear_vecs();
      va.delete(); vb.delete(); vg.delete(); vbub.delete();
   endtask

   task automatic add_vec(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ig,
                          input int bub);
      va.push_back(ia); vb.push_back(ib); vg.push_back(ig); vbub.push_back(bub);
   endtask

   // Run-level expectation: only the first num vectors count; stats saturate at 2^cntw-1.
   function automatic void model_run(input int num, input int cntw);
      int n, mx;
      n  = (num < va.size()) ? num : va.size();
      mx = (1 << cntw) - 1;
      m_pass = 0; m_fail = 0; m_idx = 0; m_got = 0; m_exp = 0;
      for (int i = 0; i < n; i++) begin
         if (vg[i] == (va[i] & vb[i])) begin
            if (m_pass < mx) m_pass++;
         end else begin
            if (m_fail == 0) begin
               m_idx = i; m_got = vg[i]; m_exp = va[i] & vb[i];
            end
            if (m_fail < mx) m_fail++;
         end
      end
      m_pflag = (m_fail == 0 && m_pass == num) ? 1 : 0;
   endfunction

   task automatic drive_run(input int s, input int num);
      logic [3:0] ra, rb;
      sel = s;
      @(negedge clk);
      start_l0 = (s == 0); start_l2 = (s == 1); start_c2 = (s == 2);
      num16 = 16'(num); num2 = 2'(num);
      // A valid-looking wrong vector in the start cycle must be ignored.
      ra = 4'($urandom); rb = 4'($urandom);
      in_valid = 1'b1; a = ra; b = rb; cur_got = ~(ra & rb);
      @(negedge clk);
      start_l0 = 1'b0; start_l2 = 1'b0; start_c2 = 1'b0;
      s_busy = o_busy; s_done = o_done; s_pc = o_pc; s_fc = o_fc; s_idx = o_idx;
      for (int i = 0; i < va.size(); i++) begin
         for (int k = 0; k < vbub[i]; k++) begin
            in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); cur_got = 4'($urandom);
            @(negedge clk);
         end
         in_valid = 1'b1; a = va[i]; b = vb[i]; cur_got = vg[i];
         @(negedge clk);
      end
      in_valid = 1'b0; cur_got = 4'($urandom);
      done_lat = -1;
      for (int c = 0; c < 40; c++) begin
         if (o_done) begin
            done_lat = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic load_directed();
      clear_vecs();
      add_vec(4'b0000, 4'b0000, 4'b0000, 0);
      add_vec(4'b1111, 4'b0101, 4'b0101, 0);
      add_vec(4'b1100, 4'b1111, 4'b1100, 0);
      add_vec(4'b1100, 4'b0011, 4'b0000, 0);
      add_vec(4'b1100, 4'b1010, 4'b1000, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if ({o_busy, o_done, o_pass, o_pc, o_fc, o_idx, o_got, o_exp} !== 59'd0) begin
            n_fail++;
            $display("FAIL reset_outputs inst=%0d got busy=%b done=%b pass=%b pc=%0d fc=%0d want all 0",
                     s, o_busy, o_done, o_pass, o_pc, o_fc);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_lat0_clean();
      load_directed();
      drive_run(0, 5);
      n_checks++;
      if (o_pc !== 16'd5 || o_fc !== 16'd0) begin
         n_fail++; $display("FAIL lat0_counts got pc=%0d fc=%0d want 5 0", o_pc, o_fc);
      end
      n_checks++;
      if (o_pass !== 1'b1 || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL lat0_pass got pass=%b busy=%b want 1 0", o_pass, o_busy);
      end
      n_checks++;
      if (done_lat < 1 || done_lat > 3) begin
         n_fail++; $display("FAIL lat0_done_latency got %0d want 1..3 cycles", done_lat);
      end
   endtask

   task automatic test_lat2_bubble();
      load_directed();
      vbub[3] = 1;
      drive_run(1, 5);
      n_checks++;
      if (o_pc !== 16'd5 || o_fc !== 16'd0 || o_pass !== 1'b1) begin
         n_fail++;
         $display("FAIL lat2_bubble got pc=%0d fc=%0d pass=%b want 5 0 1", o_pc, o_fc, o_pass);
      end
      n_checks++;
      if (done_lat < 2 || done_lat > 5) begin
         n_fail++; $display("FAIL lat2_done_after_drain got %0d want 2..5 cycles", done_lat);
      end
   endtask

   task automatic test_first_fail();
      load_directed();
      vg[1] = 4'b0000;
      drive_run(0, 5);
      n_checks++;
      if (o_fc !== 16'd1 || o_pc !== 16'd4 || o_pass !== 1'b0) begin
         n_fail++;
         $display("FAIL one_bad_counts got fc=%0d pc=%0d pass=%b want 1 4 0", o_fc, o_pc, o_pass);
      end
      n_checks++;
      if (o_idx !== 16'd1 || o_got !== 4'b0000 || o_exp !== 4'b0101) begin
         n_fail++;
         $display("FAIL one_bad_capture got idx=%0d got=%b exp=%b want 1 0000 0101",
                  o_idx, o_got, o_exp);
      end
      vg[3] = 4'b0001;
      drive_run(0, 5);
      n_checks++;
      if (o_fc !== 16'd2 || o_pc !== 16'd3 || o_idx !== 16'd1 || o_exp !== 4'b0101) begin
         n_fail++;
         $display("FAIL two_bad got fc=%0d pc=%0d idx=%0d exp=%b want 2 3 1 0101",
                  o_fc, o_pc, o_idx, o_exp);
      end
   endtask

   task automatic test_num_zero();
      clear_vecs();
      drive_run(0, 0);
      n_checks++;
      if (done_lat < 0 || done_lat > 3 || o_pass !== 1'b1) begin
         n_fail++; $display("FAIL num_zero got done_lat=%0d pass=%b want <=3 1", done_lat, o_pass);
      end
      n_checks++;
      if (o_pc !== 16'd0 || o_fc !== 16'd0) begin
         n_fail++; $display("FAIL num_zero_counts got pc=%0d fc=%0d want 0 0", o_pc, o_fc);
      end
   endtask

   task automatic test_overrun();
      load_directed();
      add_vec(4'b1111, 4'b1111, 4'b0000, 0);
      vg[3] = 4'b0110;
      vg[4] = 4'b0110;
      drive_run(0, 3);
      n_checks++;
      if (o_pc !== 16'd3 || o_fc !== 16'd0 || o_pass !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun got pc=%0d fc=%0d pass=%b want 3 0 1", o_pc, o_fc, o_pass);
      end
   endtask

   task automatic test_reset_mid_run();
      sel = 0;
      @(negedge clk);
      start_l0 = 1'b1; num16 = 16'd5;
      @(negedge clk);
      start_l0 = 1'b0;
      in_valid = 1'b1; a = 4'b0011; b = 4'b0110; cur_got = 4'b0010;
      @(negedge clk);
      a = 4'b1111; b = 4'b1001; cur_got = 4'b1001;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (o_pc !== 16'd2 || o_busy !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset got pc=%0d busy=%b want 2 1", o_pc, o_busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_busy, o_done, o_pass, o_pc, o_fc, o_idx, o_got, o_exp} !== 59'd0) begin
         n_fail++;
         $display("FAIL mid_reset got busy=%b done=%b pc=%0d fc=%0d want all 0",
                  o_busy, o_done, o_pc, o_fc);
      end
      @(negedge clk);
      rst_n = 1'b1;
      load_directed();
      drive_run(0, 5);
      n_checks++;
      if (o_pc !== 16'd5 || o_fc !== 16'd0 || o_pass !== 1'b1) begin
         n_fail++;
         $display("FAIL after_reset_run got pc=%0d fc=%0d pass=%b want 5 0 1", o_pc, o_fc, o_pass);
      end
   endtask

   task automatic test_restart_cnt2();
      clear_vecs();
      add_vec(4'b0001, 4'b0001, 4'b0001, 0);
      add_vec(4'b0010, 4'b0011, 4'b0000, 0);
      add_vec(4'b1111, 4'b1111, 4'b1111, 1);
      drive_run(2, 3);
      n_checks++;
      if (o_pc !== 16'd2 || o_fc !== 16'd1 || o_idx !== 16'd1 || o_got !== 4'b0000 ||
          o_exp !== 4'b0010 || o_pass !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt2_run1 got pc=%0d fc=%0d idx=%0d got=%b exp=%b pass=%b want 2 1 1 0000 0010 0",
                  o_pc, o_fc, o_idx, o_got, o_exp, o_pass);
      end
      clear_vecs();
      for (int i = 0; i < 4; i++) begin
         logic [3:0] ra, rb;
         ra = 4'($urandom); rb = 4'($urandom);
         add_vec(ra, rb, (i == 3) ? ~(ra & rb) : (ra & rb), 0);
      end
      drive_run(2, 3);
      n_checks++;
      if (s_done !== 1'b0 || s_busy !== 1'b1 || s_pc !== 16'd0 || s_fc !== 16'd0 ||
          s_idx !== 16'd0) begin
         n_fail++;
         $display("FAIL cnt2_restart_clear got done=%b busy=%b pc=%0d fc=%0d idx=%0d want 0 1 0 0 0",
                  s_done, s_busy, s_pc, s_fc, s_idx);
      end
      n_checks++;
      if (o_pc !== 16'd3 || o_fc !== 16'd0 || o_pass !== 1'b1 || o_got !== 4'd0) begin
         n_fail++;
         $display("FAIL cnt2_run2 got pc=%0d fc=%0d pass=%b ffgot=%b want 3 0 1 0000",
                  o_pc, o_fc, o_pass, o_got);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 24; r++) begin
         int s, num, extra;
         s     = r % 2;
         num   = int'($urandom_range(1, 12));
         extra = int'($urandom_range(0, 2));
         clear_vecs();
         for (int i = 0; i < num + extra; i++) begin
            logic [3:0] ra, rb, rg;
            ra = 4'($urandom); rb = 4'($urandom);
            rg = ra & rb;
            if ($urandom_range(0, 3) == 0) rg = rg ^ 4'($urandom_range(1, 15));
            add_vec(ra, rb, rg, int'($urandom_range(0, 2)));
         end
         drive_run(s, num);
         model_run(num, 16);
         n_checks++;
         if (done_lat < 0) begin
            n_fail++; $display("FAIL rand_done_timeout run=%0d got no done want done", r);
         end
         n_checks++;
         if (o_pc !== 16'(m_pass) || o_fc !== 16'(m_fail) || o_pass !== 1'(m_pflag)) begin
            n_fail++;
            $display("FAIL rand_counts run=%0d inst=%0d got pc=%0d fc=%0d pass=%b want %0d %0d %0d",
                     r, s, o_pc, o_fc, o_pass, m_pass, m_fail, m_pflag);
         end
         n_checks++;
         if (o_idx !== 16'(m_idx) || o_got !== 4'(m_got) || o_exp !== 4'(m_exp)) begin
            n_fail++;
            $display("FAIL rand_capture run=%0d inst=%0d got idx=%0d got=%h exp=%h want %0d %h %h",
                     r, s, o_idx, o_got, o_exp, m_idx, m_got, m_exp);
         end
      end
   endtask

   initial begin
      sel = 0;
      start_l0 = 1'b0; start_l2 = 1'b0; start_c2 = 1'b0;
      num16 = '0; num2 = '0; in_valid = 1'b0; a = '0; b = '0; cur_got = '0;
      test_reset();
      test_lat0_clean();
      test_lat2_bubble();
      test_first_fail();
      test_num_zero();
      test_overrun();
      test_reset_mid_run();
      test_restart_cnt2();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
